// File: rtl/board_pkg.sv
// Board geometry, cell type and the flat-bus cell index used by the gravity stage.
// Shared by the column compactor and the refresh top; no logic of its own.
package board_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CW   = 3;
  localparam int BW   = ROWS * COLS * CW;
  // Wide enough to hold 0..ROWS inclusive.
  localparam int RW   = $clog2(ROWS) + 1;

  typedef logic [CW-1:0] cell_t;

  localparam cell_t EMPTY = '0;

  function automatic int cell_idx(input int r, input int c);
    return (r * COLS + c) * CW;
  endfunction

endpackage

// File: rtl/column_compact.sv
// Drops the non-empty cells of one column to the bottom, preserving their order.
// Purely combinational, no backpressure; also reports whether anything moved and the empty count.
module column_compact
  import board_pkg::*;
(
  input  cell_t [ROWS-1:0] col_in,
  output cell_t [ROWS-1:0] col_out,
  output logic             col_changed,
  output logic [RW-1:0]    col_empty
);

  logic [RW-1:0] below;

  // A source cell lands at the slot equal to the number of gems beneath it.
  always_comb begin
    col_out = '0;
    below   = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (col_in[r] != EMPTY) begin
        for (int d = 0; d < ROWS; d++) begin
          if (RW'(ROWS - 1 - d) == below) begin
            col_out[d] = col_in[r];
          end
        end
        below = below + 1'b1;
      end
    end
  end

  assign col_changed = (col_out != col_in);
  assign col_empty   = RW'(ROWS) - below;

endmodule

// File: rtl/refresh.sv
// Gravity stage: compacts every column of the board in one pass and registers the result.
// Latency 1 cycle, accepts a board every cycle, no backpressure.
module refresh
  import board_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] board,
  output logic [BW-1:0] new_board,
  output logic          changed,
  output logic [6:0]    empty_cnt
);

  cell_t [ROWS-1:0] col_in  [COLS];
  cell_t [ROWS-1:0] col_out [COLS];
  logic  [COLS-1:0] col_changed;
  logic  [RW-1:0]   col_empty [COLS];

  logic [BW-1:0] board_nxt;
  logic [6:0]    empty_sum;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign col_in[c][r]                     = board[cell_idx(r, c) +: CW];
      assign board_nxt[cell_idx(r, c) +: CW]  = col_out[c][r];
    end

    column_compact u_col (
      .col_in      (col_in[c]),
      .col_out     (col_out[c]),
      .col_changed (col_changed[c]),
      .col_empty   (col_empty[c])
    );
  end

  always_comb begin
    empty_sum = '0;
    for (int c = 0; c < COLS; c++) begin
      empty_sum = empty_sum + 7'(col_empty[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      new_board <= '0;
      changed   <= 1'b0;
      empty_cnt <= '0;
    end else begin
      new_board <= board_nxt;
      changed   <= |col_changed;
      empty_cnt <= empty_sum;
    end
  end

endmodule

// File: tb/tb_refresh.sv
// Directed bench for refresh: expectations are queued when a board is driven and
// popped one edge later, so every result is checked for exactly one cycle of latency.
module tb_refresh;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [191:0] board;
  logic [191:0] new_board;
  logic         changed;
  logic [6:0]   empty_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  refresh dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .board     (board),
    .new_board (new_board),
    .changed   (changed),
    .empty_cnt (empty_cnt)
  );

  typedef struct {
    logic [191:0] nb;
    logic         ch;
    logic [6:0]   ec;
    string        tag;
  } exp_t;

  exp_t sb[$];

  function automatic logic [191:0] put(input logic [191:0] b, input int r, input int c,
                                       input logic [2:0] v);
    b[(r * 8 + c) * 3 +: 3] = v;
    return b;
  endfunction

  function automatic logic [2:0] get(input logic [191:0] b, input int r, input int c);
    return b[(r * 8 + c) * 3 +: 3];
  endfunction

  // Reference: gather gems top-down per column, then stack them against the bottom.
  function automatic logic [191:0] gravity(input logic [191:0] b);
    logic [191:0] o;
    logic [2:0]   q[$];
    o = '0;
    for (int c = 0; c < 8; c++) begin
      q.delete();
      for (int r = 0; r < 8; r++) begin
        if (get(b, r, c) != 3'd0) q.push_back(get(b, r, c));
      end
      for (int i = 0; i < q.size(); i++) begin
        o = put(o, 8 - q.size() + i, c, q[i]);
      end
    end
    return o;
  endfunction

  function automatic logic [6:0] zeros(input logic [191:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (b[i * 3 +: 3] == 3'd0) n++;
    end
    return 7'(n);
  endfunction

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [191:0] b, input logic [191:0] eb,
                       input logic ech, input logic [6:0] eec);
    exp_t e;
    board  = b;
    e.nb   = eb;
    e.ch   = ech;
    e.ec   = eec;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".new_board"}, new_board, e.nb);
      chk({e.tag, ".changed"}, 192'(changed), 192'(e.ch));
      chk({e.tag, ".empty_cnt"}, 192'(empty_cnt), 192'(e.ec));
    end
  endtask

  logic [191:0] b, eb, prev;
  logic [2:0]   colv [8];

  initial begin
    // Reset with a nonzero board present.
    rst_n = 1'b0;
    board = {64{3'd6}};
    repeat (2) @(posedge clk);
    #1;
    chk("reset.new_board", new_board, 192'd0);
    chk("reset.changed", 192'(changed), 192'd0);
    chk("reset.empty_cnt", 192'(empty_cnt), 192'd0);
    rst_n = 1'b1;

    // Row-constant board is already compact.
    b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b = put(b, r, c, 3'(r));
    drive("rowconst", b, b, 1'b0, 7'd8);
    tick_check();

    // Row 4 and column 4 cleared.
    for (int c = 0; c < 8; c++) b = put(b, 4, c, 3'd0);
    for (int r = 0; r < 8; r++) b = put(b, r, 4, 3'd0);
    colv = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    eb = '0;
    for (int c = 0; c < 8; c++)
      if (c != 4)
        for (int r = 0; r < 8; r++) eb = put(eb, r, c, colv[r]);
    drive("holes", b, eb, 1'b1, 7'd22);
    tick_check();

    // Feeding the compacted board back leaves it untouched.
    drive("feedback", new_board, eb, 1'b0, 7'd22);
    tick_check();

    // Single gem falls to the bottom row.
    b  = put(192'd0, 0, 3, 3'd5);
    eb = put(192'd0, 7, 3, 3'd5);
    drive("single", b, eb, 1'b1, 7'd63);
    tick_check();

    // Full board.
    b = {64{3'd7}};
    drive("full", b, b, 1'b0, 7'd0);
    tick_check();

    // Back-to-back random boards, one result per cycle.
    prev = '0;
    for (int k = 0; k < 12; k++) begin
      b = '0;
      for (int i = 0; i < 64; i++)
        if ($urandom_range(0, 2) != 0) b[i * 3 +: 3] = 3'($urandom_range(1, 7));
      drive($sformatf("stream%0d", k), b, gravity(b), gravity(b) != b, zeros(b));
      tick_check();
      prev = b;
    end

    // Reset mid-stream, then the first board after release.
    rst_n = 1'b0;
    board = prev;
    @(posedge clk);
    #1;
    chk("midrst.new_board", new_board, 192'd0);
    chk("midrst.changed", 192'(changed), 192'd0);
    rst_n = 1'b1;
    b = put(put(192'd0, 2, 0, 3'd3), 5, 0, 3'd4);
    eb = put(put(192'd0, 6, 0, 3'd3), 7, 0, 3'd4);
    drive("afterrst", b, eb, 1'b1, 7'd62);
    tick_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
